// File: rtl/clk_div_pkg.sv
// Shared constants and parameter checks for the clock-divider bank.
package clk_div_pkg;

    // div_out behaviour selected by the mode input
    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Default parameter values for clk_div_bank
    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_NUM_TAPS    = 4;
    localparam int unsigned DEF_DEFAULT_DIV = 2;

    // True when the parameter set is within the supported ranges
    function automatic bit params_legal(int unsigned width, int unsigned num_taps,
                                        int unsigned default_div);
        return (width >= 2) && (width <= 16) &&
               (num_taps >= 1) && (num_taps <= 16) &&
               (default_div < (32'd1 << width));
    endfunction

endpackage

// File: rtl/clk_div_tap_ctr.sv
// Free-running power-of-two tap counter with enable and synchronous clear.
module clk_div_tap_ctr #(
    parameter int unsigned NUM_TAPS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    output logic [NUM_TAPS-1:0] count
);

    // Clear overrides the increment; the counter wraps naturally from all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + NUM_TAPS'(1);
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Clock-divider bank: power-of-two taps plus a reloadable divide-by-N output.
// Optional macro CLK_DIV_BANK_ALIGN_EN: clears the tap counter whenever a new
// ratio is applied so the taps line up with the new div_out phase.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NUM_TAPS    = DEF_NUM_TAPS,
    parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [WIDTH-1:0]    div_val,
    input  logic                div_load,
    input  logic                mode,
    output logic [NUM_TAPS-1:0] taps,
    output logic                div_out,
    output logic                tick,
    output logic                pending
);

    if (!params_legal(WIDTH, NUM_TAPS, DEFAULT_DIV)) begin : g_bad_params
        $error("clk_div_bank: illegal WIDTH/NUM_TAPS/DEFAULT_DIV");
    end

`ifdef CLK_DIV_BANK_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             div_out_q, div_out_d;
    logic             apply;
    logic             terminal;
    logic [WIDTH-1:0] ratio_last;
    logic             tap_clr;

    assign ratio_last = ratio_q - WIDTH'(1);
    // A ratio of zero never reaches a terminal count.
    assign terminal   = en && (ratio_q != '0) && (cnt_q == ratio_last);
    assign tap_clr    = ALIGN && apply;

    clk_div_tap_ctr #(
        .NUM_TAPS (NUM_TAPS)
    ) u_tap_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (tap_clr),
        .count (taps)
    );

    // Next-state for the programmable counter, ratio reload and div_out.
    always_comb begin
        ratio_d   = ratio_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        div_out_d = div_out_q;
        apply     = 1'b0;

        if (en) begin
            if (ratio_q == '0) begin
                // Divider idle: nothing to wait for, so take a pending ratio now.
                cnt_d = '0;
                if (pending_q) begin
                    ratio_d   = shadow_q;
                    pending_d = 1'b0;
                    apply     = 1'b1;
                end
            end else if (terminal) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                div_out_d = (mode == MODE_PULSE) ? 1'b1 : ~div_out_q;
                if (div_load) begin
                    // Load coinciding with the terminal bypasses the shadow.
                    ratio_d   = div_val;
                    pending_d = 1'b0;
                    apply     = 1'b1;
                end else if (pending_q) begin
                    ratio_d   = shadow_q;
                    pending_d = 1'b0;
                    apply     = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                if (mode == MODE_PULSE) begin
                    div_out_d = 1'b0;
                end
            end
        end

        if (div_load) begin
            shadow_d = div_val;
            if (!terminal) begin
                pending_d = 1'b1;
            end
        end
    end

    // State registers; reset wins over en and div_load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q   <= RESET_DIV;
            shadow_q  <= RESET_DIV;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            div_out_q <= 1'b0;
        end else begin
            ratio_q   <= ratio_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            div_out_q <= div_out_d;
        end
    end

    assign div_out = div_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: scoreboard against a cycle-level model.
module tb_clk_div_bank;

    localparam int unsigned W  = 8;
    localparam int unsigned NT = 4;
    localparam int unsigned DD = 2;

`ifdef CLK_DIV_BANK_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [W-1:0]  div_val = '0;
    logic          div_load = 1'b0;
    logic          mode = 1'b0;
    logic [NT-1:0] taps;
    logic          div_out;
    logic          tick;
    logic          pending;

    clk_div_bank #(
        .WIDTH       (W),
        .NUM_TAPS    (NT),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .mode     (mode),
        .taps     (taps),
        .div_out  (div_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT-1:0] taps;
        logic          div_out;
        logic          tick;
        logic          pending;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: counts cycles since the last terminal and the ratio in force.
    int m_tap = 0, m_phase = 0, m_ratio = DD, m_shadow = DD;
    bit m_pend = 0, m_tick = 0, m_div = 0;

    task automatic model_step(input bit r, input bit e, input bit dl, input int dv, input bit md);
        bit applied = 0;
        bit term = 0;
        if (r) begin
            m_tap = 0; m_phase = 0; m_ratio = DD; m_shadow = DD;
            m_pend = 0; m_tick = 0; m_div = 0;
            return;
        end
        m_tick = 0;
        if (e) begin
            m_tap = (m_tap + 1) % (1 << NT);
            if (m_ratio == 0) begin
                m_phase = 0;
                if (m_pend) begin m_ratio = m_shadow; m_pend = 0; applied = 1; end
            end else if (m_phase + 1 == m_ratio) begin
                term = 1;
                m_phase = 0;
                m_tick = 1;
                m_div = md ? 1'b1 : !m_div;
                if (dl) begin m_ratio = dv; m_pend = 0; applied = 1; end
                else if (m_pend) begin m_ratio = m_shadow; m_pend = 0; applied = 1; end
            end else begin
                m_phase = m_phase + 1;
                if (md) m_div = 0;
            end
            if (applied && ALIGN) m_tap = 0;
        end
        if (dl) begin
            m_shadow = dv;
            if (!term) m_pend = 1;
        end
    endtask

    // Drive one cycle on the falling edge and queue what the next rising edge must produce.
    task automatic cycle(input bit r, input bit e, input bit dl, input int dv, input bit md);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; div_load = dl; div_val = W'(dv); mode = md;
        model_step(r, e, dl, dv, md);
        x.taps = m_tap[NT-1:0];
        x.div_out = m_div;
        x.tick = m_tick;
        x.pending = m_pend;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare the registered outputs just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({taps, div_out, tick, pending} !== e) begin
                    n_fail++;
                    $display("FAIL outputs@%0d: got taps=%h div_out=%b tick=%b pending=%b, expected taps=%h div_out=%b tick=%b pending=%b",
                             cyc, taps, div_out, tick, pending,
                             e.taps, e.div_out, e.tick, e.pending);
                end
            end
        end
    end

    int ticks;
    logic [NT-1:0] taps_hold;
    bit r_mode;

    initial begin
        // Reset
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("reset_outputs", int'({taps, div_out, tick, pending}), 0);

        // 1: default ratio 2, toggle mode
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 0, 0);
            ticks += int'(tick);
            if (i == 7) check("taps_after_8", int'(taps), 8);
        end
        check("ticks_ratio2", ticks, 8);
        check("taps_after_16", int'(taps), 0);

        // 2: load 3 on a non-terminal cycle, applied at the next terminal
        cycle(0, 1, 1, 3, 0);
        check("pending_after_load", int'(pending), 1);
        cycle(0, 1, 0, 0, 0);
        check("pending_cleared", int'(pending), 0);
        check("tick_on_apply", int'(tick), 1);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 0, 0, 0);
            ticks += int'(tick);
        end
        check("ticks_ratio3", ticks, 4);

        // 3: load 5 then 7 back to back; the 7 lands on a terminal
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 5, 0);
        cycle(0, 1, 1, 7, 0);
        check("bypass_pending", int'(pending), 0);
        ticks = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(0, 1, 0, 0, 0);
            ticks += int'(tick);
        end
        check("ticks_ratio7", ticks, 2);

        // 4: load 0, divider stops after the next terminal
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 0, 0);
            ticks += int'(tick);
        end
        check("ticks_ratio0", ticks, 0);
        cycle(0, 1, 1, 4, 0);
        cycle(0, 1, 0, 0, 0);
        check("ratio0_apply_pending", int'(pending), 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
        check("tick_after_4", int'(tick), 1);

        // 5: pulse mode at ratio 3, then freeze with en low
        cycle(0, 1, 1, 3, 1);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 1);
        taps_hold = taps;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 1);
            check("en_low_tick", int'(tick), 0);
        end
        check("en_low_taps", int'(taps), int'(taps_hold));
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 1);

        // 6: reset mid-count with a pending load
        cycle(0, 1, 1, 9, 0);
        cycle(1, 1, 1, 6, 0);
        check("reset_mid_count", int'({taps, div_out, tick, pending}), 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);

        // Randomised traffic
        r_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) r_mode = !r_mode;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)), r_mode);
        end

        cycle(0, 0, 0, 0, r_mode);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Parametrised clock-divider bank, the successor to the fixed div2/4/8/16 divider.
- Provides NUM_TAPS power-of-two tap outputs and one programmable divide-by-N output.
- N is reloadable at run time; ratio changes are glitch-free.
- Selectable output mode: toggle (50% duty) or single-cycle pulse.
- Sits behind the top-level wrapper; the wrapper drives en from the project enable.
- All outputs are registered. None are used as clocks internally.

Parameters:
- WIDTH, 8: bit width of the programmable ratio and its counter (2..16).
- NUM_TAPS, 4: number of power-of-two taps (1..16); tap i toggles at clk/2^(i+1).
- DEFAULT_DIV, 2: ratio loaded at reset. Must be < 2^WIDTH.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: count enable; low freezes all counters and outputs.
- div_val, input, WIDTH: new ratio N.
- div_load, input, 1: one-cycle strobe; captures div_val into the shadow register.
- mode, input, 1: 0 = toggle mode, 1 = pulse mode for div_out.
- taps, output, NUM_TAPS: power-of-two divided outputs.
- div_out, output, 1: programmable divider output.
- tick, output, 1: one-cycle strobe per programmable terminal count.
- pending, output, 1: a loaded ratio is waiting to be applied.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high.
  - Reset (at any time, including mid-count) clears all state on the next edge:
    - taps = 0, div_out = 0, tick = 0, pending = 0.
    - tap counter = 0, prog counter = 0.
    - active ratio = DEFAULT_DIV, shadow = DEFAULT_DIV.
  - reset has priority over en and div_load.
- Tap counter:
  - NUM_TAPS-bit up-counter; increments by 1 each cycle en = 1.
  - Wraps from all-ones to 0.
  - taps = counter bits directly, so taps[i] has period 2^(i+1) cycles.
- Programmable counter (ratio R = active ratio, cnt in [0, R-1]):
  - If en = 1, R != 0 and cnt == R-1 (terminal):
    - cnt <= 0 and tick <= 1 for exactly one cycle.
    - Toggle mode: div_out <= ~div_out, giving period 2R cycles.
    - Pulse mode: div_out <= 1 for one cycle, i.e. a registered copy of tick.
  - Otherwise, if en = 1 and R != 0: cnt <= cnt + 1, tick <= 0. In pulse mode div_out <= 0.
  - R = 1: terminal every enabled cycle, so tick stays high; toggle-mode period is 2 cycles.
  - R = 0: divider disabled; cnt held at 0, tick = 0, div_out holds its value.
  - en = 0: all counters hold, tick <= 0, div_out holds its value (both modes).
- Ratio reload:
  - div_load = 1: shadow <= div_val, pending <= 1.
  - A second load while pending overwrites the shadow; latest value wins.
  - At the next enabled terminal count, R <= shadow and pending <= 0.
  - Counting under the new R starts from cnt = 0.
  - div_load coincident with a terminal: the new div_val is applied at that terminal (bypass); pending stays 0.
  - When R == 0, a pending value is applied on the next en = 1 cycle, since there is no terminal to wait for.
  - Loading 0 disables the divider at the next terminal.
- Mode changes:
  - mode is sampled every cycle.
  - Switching to pulse mode forces div_out <= 0 on the next non-terminal cycle.
  - Switching to toggle mode resumes toggling from the current div_out value.
- Width rules:
  - cnt and R are WIDTH bits, unsigned; comparison R-1 uses WIDTH bits.
  - No overflow is possible because cnt < R.

Optional Feature:
- Macro: CLK_DIV_BANK_ALIGN_EN.
- Defined: on each cycle where a new ratio is applied, the tap counter is also cleared to 0 (overriding the increment). Taps are then phase-aligned to the first div_out edge of the new ratio.
- Undefined: the tap counter free-runs, unaffected by ratio changes.

Decomposition:
- Package clk_div_pkg holds:
  - mode constants MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1.
  - the default-parameter constants.
  - a function to check parameter legality, used in an elaboration-time assertion.
- Sub-module clk_div_tap_ctr (NUM_TAPS): the enable/clear tap counter.
- The programmable counter, shadow and pending logic remain in clk_div_bank.

Test Plan:
1. Reset, then en = 1, mode = 0, DEFAULT_DIV = 2, 16 cycles:
   - div_out period 4, tick every 2nd cycle.
   - taps[0] period 2, taps[3] period 16.
2. Load div_val = 3 and run:
   - pending = 1 until the next terminal.
   - Then div_out period 6 and tick every 3 cycles.
3. Mid-count, load 5 and then 7 on consecutive cycles:
   - Only 7 is applied, at the next terminal.
   - A load coincident with a terminal is applied at that same terminal.
4. Load 0:
   - After the next terminal, tick stays 0 and div_out is frozen.
   - Load 4 afterwards: applied on the next cycle; tick after 4 cycles.
5. mode = 1 with R = 3:
   - div_out is high for 1 cycle in every 3.
   - Drop en for 5 cycles: cnt and taps hold, tick = 0; counting resumes at the same cnt.
6. Assert reset mid-count with pending = 1:
   - Next cycle all outputs are 0, pending = 0, R = DEFAULT_DIV.
   - With CLK_DIV_BANK_ALIGN_EN defined, taps = 0 on the ratio-apply cycle in scenario 2.
